line_buffer_kxk_np: RTL

- Parametrised streaming window generator: P pixels/clock in, K×(P+K-1) pixel window out per accepted beat.
- Generalises the fixed 3×3/5×5, 8-pixel buffers in window size, parallelism, pixel width and frame geometry.
- Adds valid/ready back-pressure, start-of-frame resync, reset, row/beat position tags and a selectable border mode.
- Sits between the pixel unpacker and the parallel convolution / edge-filter kernels.

---
 rtl/line_buffer_kxk_np.sv | 131 +++++++++++++
 1 files changed

// File: rtl/line_buffer_kxk_np.sv
// rtl/line_buffer_kxk_np.sv - streaming K x (P+K-1) window generator, P pixels per beat
module line_buffer_kxk_np #(
  parameter int W      = 3128,
  parameter int H      = 2048,
  parameter int K      = 5,
  parameter int P      = 8,
  parameter int PIX_W  = 8,
  parameter int BORDER = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [P*PIX_W-1:0]           in_pix,
  input  logic                         in_valid,
  input  logic                         in_sof,
  output logic                         in_ready,
  output logic [K*(P+K-1)*PIX_W-1:0]   win,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  out_row,
  output logic [15:0]                  out_beat,
  output logic                         out_eof
);

  localparam int NB   = W / P;
  localparam int WC   = P + K - 1;
  localparam int AW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW   = (H > 1) ? $clog2(H) : 1;
  localparam int BW   = P * PIX_W;
  localparam int HW   = (K - 1) * PIX_W;
  localparam int RWIN = WC * PIX_W;

  if ((K % 2) == 0 || K < 3 || K > 7) begin : g_bad_k
    $error("line_buffer_kxk_np: K must be odd and within 3..7");
  end
  if ((W % P) != 0) begin : g_bad_w
    $error("line_buffer_kxk_np: W must be a multiple of P");
  end
  if (H > 65535 || NB > 65535) begin : g_bad_geom
    $error("line_buffer_kxk_np: H and W/P must not exceed 65535");
  end

  logic            accept;
  logic            emit;
  logic            last_beat;
  logic            last_row;
  logic [AW-1:0]   beat_q;
  logic [AW-1:0]   cur_beat;
  logic [RW-1:0]   row_q;
  logic [RW-1:0]   cur_row;
  logic [K*RWIN-1:0] win_d;
  logic [BW-1:0]   store_rd [K-1];

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  // A start-of-frame beat overrides the running position outright.
  assign cur_beat  = in_sof ? '0 : beat_q;
  assign cur_row   = in_sof ? '0 : row_q;
  assign last_beat = (cur_beat == AW'(NB - 1));
  assign last_row  = (cur_row == RW'(H - 1));

  if (BORDER != 0) begin : g_emit_all
    assign emit = 1'b1;
  end else begin : g_emit_full
    assign emit = (32'(cur_row) >= 32'(K - 1)) &&
                  ((32'(cur_beat) * 32'(P)) >= 32'(K - 1));
  end

  // Store 0 holds the previous row; each store passes its old entry one row further back.
  for (genvar j = 0; j < K - 1; j++) begin : g_store
    logic [BW-1:0] mem [NB];
    assign store_rd[j] = mem[cur_beat];
    if (j == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (accept) mem[cur_beat] <= in_pix;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (accept) mem[cur_beat] <= store_rd[j-1];
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    logic [BW-1:0]   raw;
    logic [BW-1:0]   col;
    logic [HW-1:0]   hist_q;
    logic [HW-1:0]   prev_h;
    logic [RWIN-1:0] cat;

    if (r == K - 1) begin : g_live
      assign raw = in_pix;
    end else begin : g_line
      assign raw = store_rd[K-2-r];
    end

    // Rows above the image (or left over from before a resync) read as zero.
    assign col    = (32'(cur_row) >= 32'(K - 1 - r)) ? raw : '0;
    assign prev_h = (cur_beat == '0) ? '0 : hist_q;
    assign cat    = {col, prev_h};
    assign win_d[r*RWIN +: RWIN] = cat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      hist_q <= '0;
      else if (accept) hist_q <= cat[RWIN-1 -: HW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      win       <= '0;
      out_row   <= '0;
      out_beat  <= '0;
      out_eof   <= 1'b0;
      row_q     <= '0;
      beat_q    <= '0;
    end else if (accept) begin
      out_valid <= emit;
      win       <= win_d;
      out_row   <= 16'(cur_row);
      out_beat  <= 16'(cur_beat);
      out_eof   <= last_beat && last_row && emit;
      beat_q    <= last_beat ? '0 : cur_beat + AW'(1);
      if (last_beat) row_q <= last_row ? '0 : cur_row + RW'(1);
      else           row_q <= cur_row;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
